// File: rtl/tc_clk_pkg.sv
// Shared types and helpers for the clock-gate controller.
package tc_clk_pkg;

  // Controller states: clock running, waiting for the gate to close,
  // clock stopped, waiting for the gate to reopen.
  typedef enum logic [1:0] {
    RUN         = 2'd0,
    GATE_WAIT   = 2'd1,
    OFF         = 2'd2,
    UNGATE_WAIT = 2'd3
  } clk_gate_state_e;

  // Width wide enough to hold the larger of the idle window and the sync latency.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tc_clk_delay_cnt.sv
// Loadable down-counter with a zero flag. It times both gate-settling waits.
module tc_clk_delay_cnt #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority. Decrement stops at zero so the flag stays stable.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tc_clk_gate_ctrl.sv
// Clock-gate controller. It closes the gate after a programmable idle window
// and reopens it on a wake request. Each enable change is held for the gate's
// sync latency, so the consumer never sees a runt pulse.
module tc_clk_gate_ctrl
  import tc_clk_pkg::*;
#(
  parameter int IDLE_CYCLES  = 16,
  parameter int SYNC_LATENCY = 3,
  parameter int EVT_CNT_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 auto_en_i,
  input  logic                 idle_i,
  input  logic                 wake_i,
  output logic                 en_o,
  output logic                 clk_active_o,
  output logic                 gated_o,
  output logic [EVT_CNT_W-1:0] evt_cnt_o
);

  localparam int CNT_W = cnt_width(IDLE_CYCLES, SYNC_LATENCY);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(SYNC_LATENCY - 1);

  clk_gate_state_e        state_q, state_d;
  logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic                   wake_pend_q, wake_pend_d;
  logic [EVT_CNT_W-1:0]   evt_cnt_q, evt_cnt_d;
  logic                   en_q, en_d;
  logic                   active_q, active_d;
  logic                   gated_q, gated_d;

  logic                   dly_load;
  logic                   dly_dec;
  logic                   dly_zero;
  logic                   gate_cond;
  logic                   wake_cond;

  assign gate_cond = auto_en_i & idle_i & ~wake_i;
  assign wake_cond = wake_i | wake_pend_q | ~auto_en_i | ~idle_i;

  tc_clk_delay_cnt #(
    .W (CNT_W)
  ) u_dly (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (dly_load),
    .load_val_i (SYNC_LOAD),
    .dec_i      (dly_dec),
    .zero_o     (dly_zero)
  );

  // Next-state logic. It also computes the idle and event counters, the
  // pending wake, and the output flags (decoded from the next state so that
  // they come out of flops).
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = '0;
    wake_pend_d = wake_pend_q;
    evt_cnt_d   = evt_cnt_q;
    dly_load    = 1'b0;
    dly_dec     = 1'b0;

    case (state_q)
      RUN: begin
        if (gate_cond) begin
          if (idle_cnt_q == IDLE_LAST) begin
            state_d  = GATE_WAIT;
            dly_load = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end

      GATE_WAIT: begin
        // A wake here is remembered, not acted on. Cutting the wait short
        // could produce a runt pulse.
        if (wake_i) begin
          wake_pend_d = 1'b1;
        end
        if (dly_zero) begin
          if (wake_cond) begin
            state_d     = UNGATE_WAIT;
            dly_load    = 1'b1;
            wake_pend_d = 1'b0;
          end else begin
            state_d = OFF;
            if (evt_cnt_q != '1) begin
              evt_cnt_d = evt_cnt_q + 1'b1;
            end
          end
        end else begin
          dly_dec = 1'b1;
        end
      end

      OFF: begin
        if (wake_cond) begin
          state_d     = UNGATE_WAIT;
          dly_load    = 1'b1;
          wake_pend_d = 1'b0;
        end
      end

      UNGATE_WAIT: begin
        if (dly_zero) begin
          state_d = RUN;
        end else begin
          dly_dec = 1'b1;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    en_d     = (state_d != GATE_WAIT) && (state_d != OFF);
    active_d = (state_d == RUN);
    gated_d  = (state_d == OFF);
  end

  // State and output registers. Reset leaves the clock running.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      idle_cnt_q  <= '0;
      wake_pend_q <= 1'b0;
      evt_cnt_q   <= '0;
      en_q        <= 1'b1;
      active_q    <= 1'b1;
      gated_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_pend_q <= wake_pend_d;
      evt_cnt_q   <= evt_cnt_d;
      en_q        <= en_d;
      active_q    <= active_d;
      gated_q     <= gated_d;
    end
  end

  assign en_o         = en_q;
  assign clk_active_o = active_q;
  assign gated_o      = gated_q;
  assign evt_cnt_o    = evt_cnt_q;

endmodule

// File: tb/tb_tc_clk_gate_ctrl.sv
// Directed bench for tc_clk_gate_ctrl with IDLE_CYCLES=4, SYNC_LATENCY=3, EVT_CNT_W=2.
module tb_tc_clk_gate_ctrl;

  logic       clk;
  logic       rst_n;
  logic       auto_en;
  logic       idle;
  logic       wake;
  logic       en;
  logic       active;
  logic       gated;
  logic [1:0] evt;

  int total = 0;
  int bad   = 0;

  tc_clk_gate_ctrl #(
    .IDLE_CYCLES  (4),
    .SYNC_LATENCY (3),
    .EVT_CNT_W    (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .auto_en_i    (auto_en),
    .idle_i       (idle),
    .wake_i       (wake),
    .en_o         (en),
    .clk_active_o (active),
    .gated_o      (gated),
    .evt_cnt_o    (evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      $display("[%0t] %s ok obs=%0h", $time, tag, obs);
    end else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Checks all three status flags at once.
  task automatic flags(input string tag, input logic e, input logic a, input logic g);
    chk({tag, ".en"}, 32'(en), 32'(e));
    chk({tag, ".active"}, 32'(active), 32'(a));
    chk({tag, ".gated"}, 32'(gated), 32'(g));
  endtask

  initial begin
    rst_n   = 1'b0;
    auto_en = 1'b1;
    idle    = 1'b0;
    wake    = 1'b0;
    tick(2);
    flags("reset", 1'b1, 1'b1, 1'b0);
    chk("reset.evt", 32'(evt), 32'd0);

    // Idle held high: en falls at edge 4, gated rises at edge 7.
    rst_n = 1'b1;
    idle  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk($sformatf("idle.e%0d.en", i), 32'(en), 32'd1);
    end
    tick(1);
    flags("idle.e4", 1'b0, 1'b0, 1'b0);
    tick(2);
    flags("idle.e6", 1'b0, 1'b0, 1'b0);
    tick(1);
    flags("idle.e7", 1'b0, 1'b0, 1'b1);
    chk("idle.evt", 32'(evt), 32'd1);

    // One-cycle wake pulse in OFF.
    wake = 1'b1;
    tick(1);
    wake = 1'b0;
    flags("wake.e1", 1'b1, 1'b0, 1'b0);
    tick(2);
    chk("wake.e3.active", 32'(active), 32'd0);
    tick(1);
    flags("wake.e4", 1'b1, 1'b1, 1'b0);
    idle = 1'b0;
    tick(2);

    // Idle high for 3 edges, low for 1 edge, then high again: the count restarts.
    idle = 1'b1;
    tick(3);
    chk("restart.hi3.en", 32'(en), 32'd1);
    idle = 1'b0;
    tick(1);
    chk("restart.lo.en", 32'(en), 32'd1);
    idle = 1'b1;
    tick(3);
    chk("restart.e3.en", 32'(en), 32'd1);
    tick(1);
    chk("restart.e4.en", 32'(en), 32'd0);

    // Wake in the 2nd cycle of GATE_WAIT: the wait completes, then the
    // gate reopens without ever reaching OFF.
    tick(1);
    flags("gw.c1", 1'b0, 1'b0, 1'b0);
    wake = 1'b1;
    tick(1);
    wake = 1'b0;
    flags("gw.c2", 1'b0, 1'b0, 1'b0);
    tick(1);
    flags("gw.end", 1'b1, 1'b0, 1'b0);
    chk("gw.evt", 32'(evt), 32'd1);
    tick(2);
    flags("gw.uw", 1'b1, 1'b0, 1'b0);
    tick(1);
    flags("gw.run", 1'b1, 1'b1, 1'b0);

    // auto_en low with idle high keeps the clock on.
    auto_en = 1'b0;
    tick(20);
    flags("noauto", 1'b1, 1'b1, 1'b0);

    // Gate again, then drop auto_en while OFF.
    auto_en = 1'b1;
    tick(7);
    flags("ae.off", 1'b0, 1'b0, 1'b1);
    chk("ae.evt", 32'(evt), 32'd2);
    auto_en = 1'b0;
    tick(1);
    flags("ae.wake", 1'b1, 1'b0, 1'b0);
    tick(3);
    flags("ae.run", 1'b1, 1'b1, 1'b0);
    auto_en = 1'b1;

    // Three more gating events: the 2-bit counter saturates at 3.
    tick(7);
    flags("sat3.off", 1'b0, 1'b0, 1'b1);
    chk("sat3.evt", 32'(evt), 32'd3);
    for (int k = 4; k <= 5; k++) begin
      wake = 1'b1;
      tick(1);
      wake = 1'b0;
      tick(3);
      chk($sformatf("sat%0d.run", k), 32'(active), 32'd1);
      tick(7);
      chk($sformatf("sat%0d.gated", k), 32'(gated), 32'd1);
      chk($sformatf("sat%0d.evt", k), 32'(evt), 32'd3);
    end

    // Asynchronous reset mid-OFF, applied between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    flags("areset", 1'b1, 1'b1, 1'b0);
    chk("areset.evt", 32'(evt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
